// File: rtl/fst_mon_pkg.sv
// fst_mon_pkg: shared state encoding and helpers for the fst run-time monitor
package fst_mon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        HALTED  = 3'd2,
        STUCK   = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] mx);
        return (v >= mx) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/fst_run_monitor_if.sv
// fst_run_monitor_if: core observation inputs and status/trace outputs of fst_run_monitor
interface fst_run_monitor_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 32,
    parameter int DEPTH = 8
);
    import fst_mon_pkg::*;
    logic                     run_en;
    logic                     halting;
    logic [PC_W-1:0]          pc;
    logic                     clear;
    logic [$clog2(DEPTH)-1:0] rd_idx;
    mon_state_t               state;
    logic                     fail;
    logic [CNT_W-1:0]         cycle_count;
    logic [PC_W-1:0]          halt_pc;
    logic [$clog2(DEPTH):0]   trace_count;
    logic [PC_W-1:0]          trace_rd_data;

    modport master (
        output run_en, halting, pc, clear, rd_idx,
        input  state, fail, cycle_count, halt_pc, trace_count, trace_rd_data
    );

    modport slave (
        input  run_en, halting, pc, clear, rd_idx,
        output state, fail, cycle_count, halt_pc, trace_count, trace_rd_data
    );
endinterface

// File: rtl/fst_mon_trace.sv
// fst_mon_trace: circular buffer of recent distinct PCs with registered indexed readout
module fst_mon_trace #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [PC_W-1:0]          wdata_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [PC_W-1:0]          rd_data_o
);
    import fst_mon_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, base;
    logic [CW-1:0]   count_q, count_d;
    logic [PC_W-1:0] rd_q, rd_d;

    // a clear coinciding with a push restarts the buffer with that push as entry 0
    assign base = clr_i ? '0 : wptr_q;

    always_comb begin
        wptr_d  = push_i ? base + AW'(1) : base;
        count_d = clr_i ? CW'(push_i) : push_i ? CW'(sat_inc(64'(count_q), 64'(DEPTH))) : count_q;
        rd_d    = ({1'b0, rd_idx_i} < count_q) ? mem_q[wptr_q - AW'(1) - rd_idx_i] : '0;
    end

    always_ff @(posedge clk)
        if (push_i) mem_q[base] <= wdata_i;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
        end

    assign count_o   = count_q;
    assign rd_data_o = rd_q;
endmodule

// File: rtl/fst_run_monitor.sv
// fst_run_monitor: classifies an fst run as halted, stuck or timed out and keeps a PC trace.
// Trace storage is built only when FST_MON_TRACE_EN is defined; otherwise trace outputs read 0.
module fst_run_monitor #(
    parameter int PC_W          = 16,
    parameter int CNT_W         = 32,
    parameter int TIMEOUT       = 100000,
    parameter int STUCK_LIMIT   = 16,
    parameter int DEPTH         = 8,
    parameter int HALT_IS_ERROR = 1
) (
    input logic              clk,
    input logic              reset,
    fst_run_monitor_if.slave m
);
    import fst_mon_pkg::*;
    localparam int SW = $clog2(STUCK_LIMIT);
    mon_state_t       state_q, state_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [PC_W-1:0]  hpc_q, hpc_d, prev_q, prev_d;
    logic [SW-1:0]    stk_q, stk_d, stk_inc;
    logic             start, changed;

    assign start   = state_q == IDLE && m.run_en;
    assign changed = m.pc != prev_q;
    assign cnt_inc = CNT_W'(sat_inc(64'(cnt_q), 64'({CNT_W{1'b1}})));
    assign stk_inc = changed ? '0 : stk_q + SW'(1);

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        hpc_d   = hpc_q;
        prev_d  = prev_q;
        stk_d   = stk_q;
        if (m.clear) begin
            state_d = IDLE;
            fail_d  = 1'b0;
            cnt_d   = '0;
            stk_d   = '0;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = CNT_W'(1);
            stk_d   = '0;
            prev_d  = m.pc;
        end else if (state_q == RUN && !m.run_en) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            cnt_d   = cnt_inc;
            stk_d   = stk_inc;
            prev_d  = m.pc;
            state_d = m.halting ? HALTED :
                      stk_inc == SW'(STUCK_LIMIT - 1) ? STUCK :
                      (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) ? fst_mon_pkg::TIMEOUT : RUN;
            hpc_d   = state_d != RUN ? m.pc : hpc_q;
            fail_d  = fail_q || state_d == STUCK || state_d == fst_mon_pkg::TIMEOUT ||
                      (HALT_IS_ERROR != 0 && state_d == HALTED);
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
            hpc_q   <= '0;
            prev_q  <= '0;
            stk_q   <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            hpc_q   <= hpc_d;
            prev_q  <= prev_d;
            stk_q   <= stk_d;
        end

    assign m.state       = state_q;
    assign m.fail        = fail_q;
    assign m.cycle_count = cnt_q;
    assign m.halt_pc     = hpc_q;

`ifdef FST_MON_TRACE_EN
    logic tr_clr, tr_push;
    // entering RUN wipes the old trace and records the starting pc in one step
    assign tr_clr  = m.clear || start;
    assign tr_push = !m.clear && (start || (state_q == RUN && m.run_en && changed));

    fst_mon_trace #(.PC_W(PC_W), .DEPTH(DEPTH)) u_trace (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tr_clr),
        .push_i    (tr_push),
        .wdata_i   (m.pc),
        .rd_idx_i  (m.rd_idx),
        .count_o   (m.trace_count),
        .rd_data_o (m.trace_rd_data)
    );
`else
    logic unused_rd_idx;
    assign unused_rd_idx   = ^m.rd_idx;
    assign m.trace_count   = '0;
    assign m.trace_rd_data = '0;
`endif
endmodule

// File: tb/tb_fst_run_monitor.sv
// tb_fst_run_monitor: two monitors (timeout 50/halt-is-error, timeout off/halt-ok) on shared stimulus
module tb_fst_run_monitor;
    import fst_mon_pkg::*;
    localparam int PW = 16, CW = 32, D = 8, SL = 16;
    logic clk = 1'b0, reset = 1'b1;
    logic run_en = 1'b0, halting = 1'b0, clr = 1'b0;
    logic [PW-1:0] pc = '0;
    logic [2:0] rd_idx = '0;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    fst_run_monitor_if #(.PC_W(PW), .CNT_W(CW), .DEPTH(D)) ifa ();
    fst_run_monitor_if #(.PC_W(PW), .CNT_W(CW), .DEPTH(D)) ifb ();
    assign ifa.run_en = run_en;
    assign ifa.halting = halting;
    assign ifa.pc = pc;
    assign ifa.clear = clr;
    assign ifa.rd_idx = rd_idx;
    assign ifb.run_en = run_en;
    assign ifb.halting = halting;
    assign ifb.pc = pc;
    assign ifb.clear = clr;
    assign ifb.rd_idx = rd_idx;

    fst_run_monitor #(.PC_W(PW), .CNT_W(CW), .TIMEOUT(50), .STUCK_LIMIT(SL), .DEPTH(D), .HALT_IS_ERROR(1))
        dut_a (.clk(clk), .reset(reset), .m(ifa));
    fst_run_monitor #(.PC_W(PW), .CNT_W(CW), .TIMEOUT(0), .STUCK_LIMIT(SL), .DEPTH(D), .HALT_IS_ERROR(0))
        dut_b (.clk(clk), .reset(reset), .m(ifb));

    typedef struct {
        int            k;
        logic [2:0]    st;
        logic          fl;
        logic [CW-1:0] cnt;
        logic [PW-1:0] hpc;
        logic [3:0]    tc;
        logic [PW-1:0] rd;
    } exp_t;
    exp_t sb[$];

    logic [2:0]    m_st [2];
    logic          m_fl [2];
    logic [CW-1:0] m_cnt [2];
    logic [PW-1:0] m_hpc [2], m_prev [2], m_rd [2];
    int            m_stk [2], m_hc [2];
    logic [PW-1:0] m_hist [2][D];
    int            to_p [2] = '{50, 0};
    bit            hie [2] = '{1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = IDLE; m_fl[k] = 1'b0; m_cnt[k] = '0; m_hpc[k] = '0;
            m_prev[k] = '0; m_rd[k] = '0; m_stk[k] = 0; m_hc[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        exp_t e;
        m_rd[k] = (int'(rd_idx) < m_hc[k]) ? m_hist[k][rd_idx] : '0;
        if (clr) begin
            m_st[k] = IDLE; m_fl[k] = 1'b0; m_cnt[k] = '0; m_hc[k] = 0; m_stk[k] = 0;
        end else if (m_st[k] == IDLE) begin
            if (run_en) begin
                m_st[k] = RUN; m_cnt[k] = 1; m_stk[k] = 0; m_prev[k] = pc;
                m_hist[k][0] = pc; m_hc[k] = 1;
            end
        end else if (m_st[k] == RUN) begin
            if (!run_en) m_st[k] = IDLE;
            else begin
                if (m_cnt[k] != '1) m_cnt[k]++;
                if (pc != m_prev[k]) begin
                    for (int i = D - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                    m_hist[k][0] = pc;
                    if (m_hc[k] < D) m_hc[k]++;
                    m_stk[k] = 0;
                end else m_stk[k]++;
                m_prev[k] = pc;
                if (halting) begin
                    m_st[k] = HALTED;
                    if (hie[k]) m_fl[k] = 1'b1;
                end else if (m_stk[k] == SL - 1) begin
                    m_st[k] = STUCK; m_fl[k] = 1'b1;
                end else if (to_p[k] != 0 && m_cnt[k] == CW'(to_p[k])) begin
                    m_st[k] = TIMEOUT; m_fl[k] = 1'b1;
                end
                if (m_st[k] != RUN) m_hpc[k] = pc;
            end
        end
        e.k = k; e.st = m_st[k]; e.fl = m_fl[k]; e.cnt = m_cnt[k]; e.hpc = m_hpc[k];
`ifdef FST_MON_TRACE_EN
        e.tc = 4'(m_hc[k]); e.rd = m_rd[k];
`else
        e.tc = '0; e.rd = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.k == 0) begin
                check($sformatf("%s.a.st", tag), 32'(ifa.state), 32'(e.st));
                check($sformatf("%s.a.fail", tag), 32'(ifa.fail), 32'(e.fl));
                check($sformatf("%s.a.cnt", tag), ifa.cycle_count, e.cnt);
                check($sformatf("%s.a.hpc", tag), 32'(ifa.halt_pc), 32'(e.hpc));
                check($sformatf("%s.a.tc", tag), 32'(ifa.trace_count), 32'(e.tc));
                check($sformatf("%s.a.rd", tag), 32'(ifa.trace_rd_data), 32'(e.rd));
            end else begin
                check($sformatf("%s.b.st", tag), 32'(ifb.state), 32'(e.st));
                check($sformatf("%s.b.fail", tag), 32'(ifb.fail), 32'(e.fl));
                check($sformatf("%s.b.cnt", tag), ifb.cycle_count, e.cnt);
                check($sformatf("%s.b.hpc", tag), 32'(ifb.halt_pc), 32'(e.hpc));
                check($sformatf("%s.b.tc", tag), 32'(ifb.trace_count), 32'(e.tc));
                check($sformatf("%s.b.rd", tag), 32'(ifb.trace_rd_data), 32'(e.rd));
            end
        end
    endtask

    task automatic do_clear();
        clr = 1'b1; run_en = 1'b0; halting = 1'b0;
        tick("clr");
        clr = 1'b0;
    endtask

    initial begin
        int tc_end;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.st", 32'(ifa.state), 32'(IDLE));
        check("rst.fail", 32'(ifa.fail), 0);
        check("rst.cnt", ifa.cycle_count, 0);
        check("rst.hpc", 32'(ifa.halt_pc), 0);
        check("rst.tc", 32'(ifa.trace_count), 0);
        check("rst.rd", 32'(ifa.trace_rd_data), 0);
        reset = 1'b0;

        for (int c = 0; c <= 10; c++) begin
            run_en = 1'b1; pc = PW'(c); halting = (c == 10);
            tick("halt");
        end
        check("halt.a.st", 32'(ifa.state), 32'(HALTED));
        check("halt.a.hpc", 32'(ifa.halt_pc), 10);
        check("halt.a.cnt", ifa.cycle_count, 11);
        check("halt.a.fail", 32'(ifa.fail), 1);
        check("halt.b.st", 32'(ifb.state), 32'(HALTED));
        check("halt.b.fail", 32'(ifb.fail), 0);
        halting = 1'b0;
        run_en = 1'b0; tick("term");
        run_en = 1'b1; pc = 16'h77; tick("term");
        check("term.a.st", 32'(ifa.state), 32'(HALTED));
        do_clear();

        for (int c = 0; c <= 31; c++) begin
            run_en = 1'b1; pc = (c < 16) ? PW'(16'h10 + c) : 16'h20;
            tick("stuck");
            if (c == 30) check("stuck.pre.st", 32'(ifa.state), 32'(RUN));
        end
        check("stuck.a.st", 32'(ifa.state), 32'(STUCK));
        check("stuck.a.fail", 32'(ifa.fail), 1);
        check("stuck.a.hpc", 32'(ifa.halt_pc), 32'h20);
        check("stuck.b.fail", 32'(ifb.fail), 1);

        do_clear();
        check("clr.a.st", 32'(ifa.state), 32'(IDLE));
        check("clr.a.fail", 32'(ifa.fail), 0);
        tc_end = 0;
        for (int c = 0; c < 100; c++) begin
            run_en = 1'b1; pc = PW'(16'h100 + c);
            tick("tmo");
            tc_end = c;
            if (c == 0) begin
                check("restart.st", 32'(ifa.state), 32'(RUN));
                check("restart.cnt", ifa.cycle_count, 1);
            end
            if (ifa.state != RUN) break;
        end
        check("tmo.a.st", 32'(ifa.state), 32'(TIMEOUT));
        check("tmo.a.cnt", ifa.cycle_count, 50);
        check("tmo.a.fail", 32'(ifa.fail), 1);
        for (int i = 1; i <= 1000; i++) begin
            pc = PW'(16'h100 + tc_end + i);
            tick("notmo");
        end
        check("notmo.b.st", 32'(ifb.state), 32'(RUN));
        check("notmo.b.fail", 32'(ifb.fail), 0);
        check("notmo.b.cnt", ifb.cycle_count, 1050);

        for (int h = 1; h >= 0; h--) begin
            do_clear();
            for (int c = 0; c <= 49; c++) begin
                run_en = 1'b1; pc = PW'((c < 34) ? c : 34); halting = (h == 1 && c == 49);
                tick("prio");
            end
            halting = 1'b0;
            check("prio.a.st", 32'(ifa.state), (h == 1) ? 32'(HALTED) : 32'(STUCK));
            check("prio.a.hpc", 32'(ifa.halt_pc), 34);
            check("prio.a.cnt", ifa.cycle_count, 50);
            check("prio.b.fail", 32'(ifb.fail), (h == 1) ? 0 : 1);
        end

        do_clear();
        for (int c = 0; c <= 10; c++) begin
            run_en = 1'b1; pc = PW'(c + 1);
            tick("wrap");
        end
        run_en = 1'b0;
        tick("wrap");
        check("wrap.a.st", 32'(ifa.state), 32'(IDLE));
        for (int i = 0; i < D; i++) begin
            rd_idx = 3'(i);
            tick("rd");
`ifdef FST_MON_TRACE_EN
            check($sformatf("rd%0d", i), 32'(ifa.trace_rd_data), 32'(11 - i));
`else
            check($sformatf("rd%0d", i), 32'(ifa.trace_rd_data), 0);
`endif
        end
`ifdef FST_MON_TRACE_EN
        check("wrap.tc", 32'(ifa.trace_count), 8);
`else
        check("wrap.tc", 32'(ifa.trace_count), 0);
`endif
        do_clear();
        run_en = 1'b1; pc = 16'd5; tick("short");
        pc = 16'd6; tick("short");
        run_en = 1'b0; rd_idx = 3'd5; tick("short");
        check("rd.beyond", 32'(ifa.trace_rd_data), 0);
        rd_idx = 3'd1; tick("short");
`ifdef FST_MON_TRACE_EN
        check("rd.old", 32'(ifa.trace_rd_data), 5);
`else
        check("rd.old", 32'(ifa.trace_rd_data), 0);
`endif

        for (int c = 0; c < 5; c++) begin
            run_en = 1'b1; pc = PW'(16'h40 + c);
            tick("mid");
        end
        #3;
        reset = 1'b1;
        #1;
        check("arst.st", 32'(ifa.state), 32'(IDLE));
        check("arst.fail", 32'(ifa.fail), 0);
        check("arst.cnt", ifa.cycle_count, 0);
        check("arst.hpc", 32'(ifa.halt_pc), 0);
        check("arst.tc", 32'(ifa.trace_count), 0);
        check("arst.rd", 32'(ifa.trace_rd_data), 0);
        check("arst.b.cnt", ifb.cycle_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_en = 1'b0;
        tick("post");
        tick("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fst_run_monitor.md
Name: fst_run_monitor

Overview:
Synthesizable run-time monitor for the fst core, replacing ad-hoc halt checks in benches with a reusable, parametrised checker. Watches halting and pc_out once the core is released from reset, and classifies the run as halted, stuck (PC frozen) or timed out. Keeps a circular trace of recently executed distinct PCs for post-mortem readout. Sits beside fst in both the testbench and the FPGA top; its status drives LEDs or a debug port.

Parameters:
PC_W, 16, width of the monitored program counter
CNT_W, 32, width of the cycle counter (saturating)
TIMEOUT, 100000, cycles in RUN before TIMEOUT fires; 0 disables the timeout
STUCK_LIMIT, 16, consecutive cycles of unchanged pc (halting low) that declare STUCK; must be at least 2
DEPTH, 8, trace buffer entries; power of two, at least 2
HALT_IS_ERROR, 1, 1: a halt sets fail; 0: a halt is a normal completion

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run_en  in  1  core released and running (the core's reset_n)
halting  in  1  core halt indication
pc  in  PC_W  core program counter
clear  in  1  synchronous return to IDLE; also clears counters and the trace
rd_idx  in  $clog2(DEPTH)  trace read index; 0 = most recent entry
state  out  3  encoded monitor state (see package)
fail  out  1  sticky failure flag
cycle_count  out  CNT_W  cycles spent in RUN
halt_pc  out  PC_W  pc captured on the entry cycle to HALTED/STUCK/TIMEOUT
trace_count  out  $clog2(DEPTH)+1  valid trace entries, saturates at DEPTH
trace_rd_data  out  PC_W  registered trace read data

Behaviour:
- Reset (async, active-high): state=IDLE; fail=0; cycle_count=0; halt_pc=0; trace_count=0; trace_rd_data=0; trace write pointer=0; stuck counter=0.
- States: IDLE, RUN, HALTED, STUCK, TIMEOUT. HALTED, STUCK and TIMEOUT are terminal; only reset or clear leaves them.
- IDLE->RUN on the first cycle run_en=1. On that cycle pc is loaded as trace entry 0, and cycle_count goes to 1.
- RUN, each cycle:
  - cycle_count increments and saturates at all-ones.
  - If pc differs from the previous pc, it is pushed into the trace and the stuck counter resets to 0; otherwise the stuck counter increments.
- RUN exit priority within a cycle: halting -> HALTED; else stuck counter reaches STUCK_LIMIT-1 (so STUCK_LIMIT identical samples) -> STUCK; else TIMEOUT!=0 and cycle_count reaches TIMEOUT -> TIMEOUT.
- Exit cycle: the transition registers on the same edge, halt_pc<=pc and cycle_count stops incrementing.
- fail: set on entry to STUCK or TIMEOUT; set on entry to HALTED only when HALT_IS_ERROR=1. Sticky.
- run_en falling in RUN -> IDLE. Counters and trace hold their values until the next IDLE->RUN, which clears them. run_en is ignored in terminal states.
- clear has priority over every transition: state=IDLE, fail=0, cycle_count=0, trace_count=0, stuck counter=0.
- Trace buffer is a circular DEPTH-entry RAM. The write pointer wraps modulo DEPTH and trace_count saturates. rd_idx>=trace_count returns 0. trace_rd_data updates one cycle after rd_idx and reflects pushes from earlier cycles. Reading is legal in any state.
- Reset mid-RUN aborts immediately with no halt_pc capture.

Optional Feature:
FST_MON_TRACE_EN:
- Defined: trace buffer, trace_count and trace_rd_data behave as above.
- Undefined: no trace storage is built; trace_count and trace_rd_data are constant 0; state, fail and counter behaviour are identical.

Decomposition:
- Package fst_mon_pkg:
  - mon_state_t enum with 3-bit encodings IDLE=0, RUN=1, HALTED=2, STUCK=3, TIMEOUT=4.
  - Helper function for saturating increment.
- Sub-module fst_mon_trace: circular PC buffer with push, clear and registered indexed read, parametrised by PC_W and DEPTH. Instantiated only under FST_MON_TRACE_EN.

Test Plan:
- Halt path: run_en=1 at cycle 0, pc counts 0,1,2,..., halting=1 at cycle 10 -> state=HALTED at cycle 11, halt_pc=10, cycle_count=11, fail=1; with HALT_IS_ERROR=0, fail=0.
- Stuck path: pc increments to 0x20 then holds, halting=0, STUCK_LIMIT=16 -> STUCK on the 16th identical sample, fail=1, halt_pc=0x20.
- Timeout path: TIMEOUT=50, pc always changing -> TIMEOUT with cycle_count=50; with TIMEOUT=0, still RUN after 1000 cycles and no fail.
- Priority: halting=1 on the same cycle the stuck limit and TIMEOUT are reached -> HALTED.
- Trace wrap (FST_MON_TRACE_EN): DEPTH=8, push pcs 1..11 -> trace_count=8; rd_idx 0..7 returns 11,10,...,4 one cycle later; rd_idx beyond trace_count -> 0.
- Reset/clear: async reset asserted mid-RUN between clock edges -> all outputs 0 immediately; clear in STUCK -> IDLE, fail=0; then run_en -> RUN restarts with cycle_count=1.
